// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter in front of the 4:1 byte multiplexer.
// Package name is kept short because every arbiter file imports it.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter, plus the mux controls it drives.
// Handshake: a requester holds req[i] high for as long as it wants the channel; it owns the
// channel on every cycle where gnt[i] is high, and dropping req[i] releases it at the next edge.
interface mux_rr_arbiter_if
    import mux_arb_pkg::*;
();
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             en;
    logic             owner_chg;

    modport master (
        input  req,
        output gnt,
        output sel,
        output en,
        output owner_chg
    );

    modport slave (
        output req,
        input  gnt,
        input  sel,
        input  en,
        input  owner_chg
    );
endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr, modulo N_REQ,
// optionally ignoring one index (the current owner).
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             excl_en,
    input  logic [SEL_W-1:0] excl_idx,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [N_REQ-1:0] masked;
    logic [SEL_W-1:0] cand;

    always_comb begin
        masked = req;
        if (excl_en) begin
            masked = req & ~idx2onehot(excl_idx);
        end
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // Walk from the farthest offset down so the nearest hit is written last and wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (masked[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4-input byte multiplexer; drives sel/en from registered state.
// An owner keeps the channel while requesting, but yields after MAX_HOLD cycles if others wait.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_rr_arbiter_if.master    bus,
    output arb_state_e          state_dbg
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    arb_state_e       state_q;
    logic [SEL_W-1:0] ptr_q;
    logic [CNT_W-1:0] hold_q;
    logic [N_REQ-1:0] gnt_q;
    logic [SEL_W-1:0] sel_q;
    logic             en_q;
    logic             owner_chg_q;

    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             busy;
    logic             owner_req;
    logic             hand_over;

    assign busy      = (state_q == ST_BUSY);
    assign owner_req = bus.req[sel_q];

    // While busy the search starts just past the owner and skips it, so pick_found
    // means "someone else is waiting" and pick_idx is the successor in rotation order.
    assign pick_ptr  = busy ? (sel_q + SEL_W'(1)) : ptr_q;
    assign hand_over = busy && (!owner_req || ((hold_q == HOLD_MAX) && pick_found));

    rr_pick u_pick (
        .req      (bus.req),
        .ptr      (pick_ptr),
        .excl_en  (busy),
        .excl_idx (sel_q),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            hold_q      <= '0;
            gnt_q       <= '0;
            sel_q       <= '0;
            en_q        <= 1'b0;
            owner_chg_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        state_q     <= ST_BUSY;
                        gnt_q       <= idx2onehot(pick_idx);
                        sel_q       <= pick_idx;
                        en_q        <= 1'b1;
                        owner_chg_q <= 1'b1;
                        hold_q      <= CNT_W'(1);
                    end else begin
                        owner_chg_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (hand_over) begin
                        ptr_q <= sel_q + SEL_W'(1);
                        if (pick_found) begin
                            gnt_q       <= idx2onehot(pick_idx);
                            sel_q       <= pick_idx;
                            en_q        <= 1'b1;
                            owner_chg_q <= 1'b1;
                            hold_q      <= CNT_W'(1);
                        end else begin
                            // sel keeps its last value so the mux input does not glitch while idle.
                            state_q     <= ST_IDLE;
                            gnt_q       <= '0;
                            en_q        <= 1'b0;
                            owner_chg_q <= 1'b0;
                            hold_q      <= '0;
                        end
                    end else begin
                        owner_chg_q <= 1'b0;
                        if (hold_q < HOLD_MAX) begin
                            hold_q <= hold_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.en        = en_q;
    assign bus.owner_chg = owner_chg_q;
    assign state_dbg     = state_q;

endmodule
